// File: rtl/serializer_8.sv
// Parallel-to-serial converter: captures an N-bit word and streams it out one
// bit per accepted beat, index 0 first, with zero-bubble back-to-back reload.
module serializer_8 #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:N-1] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_bit,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready
);

  localparam int            SW   = $clog2(N);
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        r_state;
  logic [SW-1:0] r_sel;
  logic [0:N-1]  r_word;
  logic          r_out_valid;
  logic          r_out_last;

  logic [SW-1:0] w_sel_next;
  logic          w_mux_bit;
  logic          w_sel_at_last;

  assign w_sel_next    = r_sel + 1'b1;
  assign w_sel_at_last = (r_sel == LAST);
  assign w_mux_bit     = r_word[r_sel];

  // in_ready depends on out_ready combinationally so a new word can be taken
  // on the same edge that retires the last bit; reset forces it low at once.
  assign in_ready  = !rst && ((r_state == IDLE) || (w_sel_at_last && out_ready));
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_bit   = r_out_valid & w_mux_bit;

  // NOTE: async reset in the sensitivity list and <= for every state element, so all registers
  // (including the word register, which must read back as zero) clear without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_word      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_word      <= in_data;
            r_sel       <= '0;
            r_state     <= SHIFT;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
          end
        end
        SHIFT: begin
          if (out_ready) begin
            if (w_sel_at_last) begin
              if (in_valid) begin
                r_word     <= in_data;
                r_sel      <= '0;
                r_out_last <= 1'b0;
              end else begin
                r_state     <= IDLE;
                r_sel       <= '0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
              end
            end else begin
              r_sel      <= w_sel_next;
              r_out_last <= (w_sel_next == LAST);
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_8.sv
// Self-checking bench for serializer_8: directed scenarios plus random traffic,
// checked against a bit-queue model of the serial stream.
module tb_serializer_8;

  logic       clk;
  logic       rst;
  logic [0:7] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       out_bit;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;

  int total = 0;
  int bad   = 0;

  // Model: bits still to be delivered, oldest first; got = bits delivered.
  logic q[$];
  logic got[$];

  logic obs_in_ready;
  logic obs_out_valid;

  serializer_8 #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive on the falling edge, check outputs, advance model.
  task automatic cycle(input logic iv, input logic [0:7] id, input logic ordy);
    logic exp_valid;
    logic exp_ready;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    exp_valid = (q.size() > 0);
    exp_ready = (q.size() == 0) || (q.size() == 1 && ordy);
    obs_in_ready  = in_ready;
    obs_out_valid = out_valid;
    check("out_valid", out_valid, exp_valid);
    check("in_ready", in_ready, exp_ready);
    if (exp_valid) begin
      check("out_bit", out_bit, q[0]);
      check("out_last", out_last, q.size() == 1);
    end else begin
      check("idle_bit", out_bit, 1'b0);
      check("idle_last", out_last, 1'b0);
    end
    @(posedge clk);
    if (exp_valid && ordy) got.push_back(q.pop_front());
    if (exp_ready && iv) for (int i = 0; i < 8; i++) q.push_back(id[i]);
  endtask

  task automatic check_seq(input string tag, input int n, input logic [15:0] exp);
    logic [15:0] v;
    v = '0;
    foreach (got[i]) v = {v[14:0], got[i]};
    check({tag, "_len"}, got.size(), n);
    check(tag, v, exp);
    got.delete();
  endtask

  initial begin
    int guard;
    int rdy_cnt;
    int val_cnt;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    check("rst_bit", out_bit, 1'b0);
    check("rst_last", out_last, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Alternating pattern at full rate, then back to idle.
    cycle(1'b1, 8'b10101010, 1'b1);
    repeat (8) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check_seq("seq_aa", 8, 16'h00AA);

    // Stall every other cycle.
    cycle(1'b1, 8'b11000001, 1'b1);
    guard = 0;
    while (got.size() < 8 && guard < 40) begin
      cycle(1'b0, 8'h00, guard[0] ? 1'b1 : 1'b0);
      guard++;
    end
    check("stall_timeout", guard < 40, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check_seq("seq_c1", 8, 16'h00C1);

    // Back-to-back words with in_valid held high.
    cycle(1'b1, 8'hF0, 1'b1);
    rdy_cnt = 0; val_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(i < 8, 8'h0F, 1'b1);
      rdy_cnt += int'(obs_in_ready);
      val_cnt += int'(obs_out_valid);
    end
    check("b2b_ready_pulses", rdy_cnt, 2);
    check("b2b_no_bubble", val_cnt, 16);
    cycle(1'b0, 8'h00, 1'b1);
    check_seq("seq_f00f", 16, 16'hF00F);

    // Reset after three bits of 0xFF.
    cycle(1'b1, 8'hFF, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_bit", out_bit, 1'b0);
    q.delete(); got.delete();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    cycle(1'b1, 8'h01, 1'b1);
    repeat (8) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check_seq("seq_01", 8, 16'h0001);

    // in_data changes while shifting must not leak through.
    cycle(1'b1, 8'hAA, 1'b1);
    repeat (8) cycle(1'b0, 8'h00, 1'b1);
    check_seq("seq_hold_aa", 8, 16'h00AA);

    // Five-cycle stall on the last bit.
    cycle(1'b1, 8'h81, 1'b1);
    repeat (7) cycle(1'b0, 8'h00, 1'b1);
    repeat (5) begin
      cycle(1'b1, 8'h55, 1'b0);
      check("stall_last", out_last, 1'b1);
      check("stall_ready", obs_in_ready, 1'b0);
    end
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check_seq("seq_81", 8, 16'h0081);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serializer_8.md
SERIALIZER_8 -- requirements
Module: serializer_8

Interface
REQ-001 SHALL have parameter N, default 8: word width in bits; power of two, at least 2.
REQ-002 SHALL have internal select counter width $clog2(N); for N=8 the counter is 3 bits, matching the mux_8 select width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_data  input  [0:N-1]  parallel word; bit 0 is transmitted first.
REQ-006 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-007 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-008 SHALL have port out_bit  output  1  current serial bit, equal to captured_word[sel].
REQ-009 SHALL have port out_valid  output  1  out_bit is meaningful.
REQ-010 SHALL have port out_last  output  1  current bit is the final bit (index N-1) of the word.
REQ-011 SHALL have port out_ready  input  1  downstream consumes out_bit this cycle.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-013 In IDLE, the block SHALL drive in_ready=1, out_valid=0, out_bit=0 and out_last=0.
REQ-014 In IDLE, when in_valid=1 at a rising edge, the block SHALL:
- capture in_data into an internal N-bit word register,
- set sel=0,
- go to SHIFT.
REQ-015 In SHIFT, the block SHALL drive out_valid=1 and out_bit=word[sel], selected through an internal N:1 mux indexed by sel.
REQ-016 In SHIFT, out_last SHALL be 1 exactly when sel==N-1.
REQ-017 A beat transfers when out_valid && out_ready at a rising edge; on a non-last beat, sel SHALL increment by 1.
REQ-018 With out_ready=0 in SHIFT, sel, word and all outputs SHALL hold unchanged, with no bit lost or repeated.
REQ-019 In SHIFT, in_ready SHALL be 1 only when sel==N-1 && out_ready=1 (last-beat transfer); it SHALL be 0 in every other SHIFT cycle.
REQ-020 On a last-beat transfer with in_valid=1, the block SHALL capture the new word, set sel=0 and stay in SHIFT (zero-bubble back-to-back).
REQ-021 On a last-beat transfer with in_valid=0, the block SHALL go to IDLE.
REQ-022 Changes on in_data while in SHIFT (other than an accepted capture) SHALL NOT affect out_bit.
REQ-023 Steady-state latency SHALL be as follows:
- first bit valid one cycle after word acceptance;
- a full word takes N cycles with out_ready held at 1;
- throughput is one bit per cycle.
REQ-024 sel SHALL never exceed N-1; there is no wrap except via the REQ-020 reload to 0.

Reset
REQ-025 While rst=1, the block SHALL immediately, without waiting for clk:
- force state=IDLE, sel=0 and word=0,
- drive out_valid=0, out_bit=0, out_last=0 and in_ready=0.
REQ-026 Reset asserted mid-word SHALL discard the remaining bits; no partial word resumes afterwards.
REQ-027 After rst deasserts, the block SHALL be in IDLE with in_ready=1; the first rising edge with in_valid=1 SHALL accept a word.

Verification
REQ-028 The bench SHALL cover: in_data=8'b10101010, out_ready=1 -> out_bit 1,0,1,0,1,0,1,0 on 8 consecutive cycles, out_last=1 only on the 8th, then IDLE with out_valid=0.
REQ-029 The bench SHALL cover: in_data=8'b11000001, out_ready toggled 1,0,1,0,... -> each bit held during stall cycles; sequence 1,1,0,0,0,0,0,1 is delivered with no loss or duplication.
REQ-030 The bench SHALL cover: words 8'hF0 then 8'h0F with in_valid held 1 -> 16 contiguous valid bits 1111 0000 0000 1111, in_ready pulsed only on the two last-beat cycles, and no bubble between words.
REQ-031 The bench SHALL cover: rst asserted after 3 bits of 8'hFF -> out_valid=0 before the next clk edge; after release, the block returns to IDLE with in_ready=1, and a new word 8'h01 yields 0,0,0,0,0,0,0,1.
REQ-032 The bench SHALL cover: in_data changed to 8'h00 during SHIFT of 8'hAA with in_valid=0 -> output remains the 8'hAA bit sequence.
REQ-033 The bench SHALL cover: out_ready=0 held for 5 cycles on the last bit -> out_last, out_bit and in_ready stay constant (in_ready=0) until out_ready=1.
